tpu_host_bridge: RTL and testbench
==================================

# tpu_host_bridge

Host-side initiator for the 4x4 systolic TPU core. It accepts a job descriptor (K, M, N) and then a stream of packed operand words, which it writes into global buffers A and B. It then starts the TPU with a one-cycle `tpu_in_valid` pulse, waits for `tpu_busy` to complete a full high/low cycle, and streams every 128-bit word of global buffer C back to the host over a valid/ready interface.

## Interface
- `IDX_W`, 16, buffer index width for A/B/C.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_valid` in 1: job descriptor valid.
- `cfg_ready` out 1: descriptor accepted; high only in IDLE.
- `cfg_k`, `cfg_m`, `cfg_n` in 8 each: inner dimension, A rows, B columns.
- `cfg_err` out 1: one-cycle pulse when a descriptor has a zero field.
- `wr_valid` in 1: operand word valid.
- `wr_ready` out 1: operand word accepted.
- `wr_data` in 32: packed operand word, byte [31:24] first lane.
- `res_valid` out 1: C word valid.
- `res_ready` in 1: host accepts C word.
- `res_data` out 128: C word.
- `res_last` out 1: marks the final C word of the job.
- `done` out 1: one-cycle pulse after the last C word handshake.
- `buf_own` out 1: 1 = bridge owns the buffer ports; the top-level muxes the buffers to the TPU when this is 0.
- `A_wr_en` out 1, `A_index` out IDX_W, `A_data_in` out 32: buffer A write port.
- `B_wr_en` out 1, `B_index` out IDX_W, `B_data_in` out 32: buffer B write port.
- `C_index` out IDX_W, `C_data_out` in 128: buffer C read port, synchronous, 1-cycle read latency.
- `tpu_in_valid` out 1, `tpu_K`, `tpu_M`, `tpu_N` out 8 each: TPU start port.
- `tpu_busy` in 1: TPU busy flag.

## Operation
- States: IDLE, LOAD_A, LOAD_B, START, WAIT_HI, WAIT_LO, RD_ISSUE, RD_CAP, RD_HOLD, DONE.
- IDLE → LOAD_A on `cfg_valid`, with all fields nonzero. On acceptance, latch K/M/N and compute:
  - `na = K*ceil(M/4)`
  - `nb = K*ceil(N/4)`
  - `nc = M*ceil(N/4)`
  - All three are 16-bit; the maximum is 16320, so there is no overflow.
- If any field is zero: pulse `cfg_err`, stay in IDLE, and do not write any buffer.
- LOAD_A:
  - `wr_ready=1`; `A_wr_en = wr_valid`; `A_data_in = wr_data`.
  - `A_index` starts at 0 and increments on each handshake.
  - After handshake `na`, go to LOAD_B.
- LOAD_B: same as LOAD_A on port B, using `nb` and its own index starting at 0, then go to START.
- START: `tpu_in_valid=1` for exactly one cycle, with `tpu_K/M/N` driven from the latched values (held through WAIT_LO). Then go to WAIT_HI.
- WAIT_HI → WAIT_LO when `tpu_busy=1`. WAIT_LO → RD_ISSUE when `tpu_busy=0`.
- RD_ISSUE: drive `C_index` = read counter, then go to RD_CAP.
- RD_CAP: register `C_data_out` into `res_data`, set `res_valid`, and go to RD_HOLD. `res_last` is set when counter = `nc-1`.
- RD_HOLD: hold `res_data`/`res_valid`/`res_last` stable until `res_ready`. On handshake:
  - Clear `res_valid` and increment the counter.
  - Go to DONE if `res_last`, otherwise to RD_ISSUE.
- DONE: pulse `done`, clear counters, go to IDLE.
- `buf_own` = 0 in START, WAIT_HI and WAIT_LO; 1 otherwise.
- `wr_valid` outside LOAD_A/LOAD_B is ignored (`wr_ready=0`).
- `cfg_valid` outside IDLE is ignored (`cfg_ready=0`).

## Timing
- Reset values:
  - State IDLE; all counters and indices 0.
  - `res_data` 0.
  - `res_valid`, `res_last`, `done`, `cfg_err`, `tpu_in_valid`, `A_wr_en`, `B_wr_en`, `wr_ready` all 0.
  - `cfg_ready` = 1, `buf_own` = 1.
- Reset asserted mid-job: immediate return to the reset values. Buffer contents and the TPU are not touched further.
- Buffer write occurs in the same cycle as the `wr_valid && wr_ready` handshake. The index updates on the following edge.
- With host `wr_valid` held high, loading takes one word per cycle: `na+nb` cycles.
- `tpu_in_valid` is asserted in the cycle after the last B handshake.
- C readout: the first `res_valid` appears 2 cycles after `tpu_busy` is sampled low. With `res_ready` held high, throughput is one word per 3 cycles (ISSUE, CAP, HOLD).
- `done` is asserted the cycle after the final C handshake. `cfg_ready` returns the cycle after that.
- `tpu_busy` already high on entry to WAIT_HI is legal and passes through in one cycle.
- `res_ready` low indefinitely: the bridge stalls in RD_HOLD with the data stable, and issues no new `C_index`.

## Test plan
- K=2, M=4, N=4, A words {01020304, 05060708}, B words {01000000, 00010000}, with a TPU model → `na=2` and `nb=2` written at indices 0–1; one `tpu_in_valid` pulse; 4 C words returned; `res_last` on the 4th; one `done` pulse.
- K=3, M=5, N=9 → `na=6`, `nb=9`, `nc=15`; `A_index` spans 0–5 and `B_index` spans 0–8; exactly 15 `res_valid` handshakes with `C_index` 0–14.
- `cfg_m=0` → `cfg_err` pulses one cycle; no `A_wr_en`/`B_wr_en`/`tpu_in_valid`; `cfg_ready` stays 1.
- Random `wr_valid` gaps and `res_ready` held low for 10 cycles on word 2 → no buffer writes during gaps; `res_data` stable over the 10 cycles; `C_index` unchanged while stalled.
- `rst_n` asserted during LOAD_B (after 1 of 2 B words) → all outputs at their reset values immediately; next job K=1, M=1, N=1 completes with `nc=1` and `res_last` on the first word.
- `tpu_busy` model rising 3 cycles after `tpu_in_valid` and high for 20 cycles → `buf_own=0` throughout; first `C_index` issued 1 cycle after busy falls.

Source files
------------

// File: rtl/tpu_host_bridge.sv
// Host-side initiator for the 4x4 systolic TPU: loads operand buffers A/B from a
// word stream, kicks the TPU, waits for it to finish, then streams buffer C back.
module tpu_host_bridge #(
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [7:0]       cfg_k,
  input  logic [7:0]       cfg_m,
  input  logic [7:0]       cfg_n,
  output logic             cfg_err,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [127:0]     res_data,
  output logic             res_last,
  output logic             done,
  output logic             buf_own,
  output logic             A_wr_en,
  output logic [IDX_W-1:0] A_index,
  output logic [31:0]      A_data_in,
  output logic             B_wr_en,
  output logic [IDX_W-1:0] B_index,
  output logic [31:0]      B_data_in,
  output logic [IDX_W-1:0] C_index,
  input  logic [127:0]     C_data_out,
  output logic             tpu_in_valid,
  output logic [7:0]       tpu_K,
  output logic [7:0]       tpu_M,
  output logic [7:0]       tpu_N,
  input  logic             tpu_busy
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] LOAD_A   = 4'd1;
  localparam logic [3:0] LOAD_B   = 4'd2;
  localparam logic [3:0] START    = 4'd3;
  localparam logic [3:0] WAIT_HI  = 4'd4;
  localparam logic [3:0] WAIT_LO  = 4'd5;
  localparam logic [3:0] RD_ISSUE = 4'd6;
  localparam logic [3:0] RD_CAP   = 4'd7;
  localparam logic [3:0] RD_HOLD  = 4'd8;
  localparam logic [3:0] DONE     = 4'd9;

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  // outer * ceil(dim/4): number of packed words covering one operand matrix
  function automatic logic [IDX_W-1:0] tile_words(input logic [7:0] outer,
                                                  input logic [7:0] dim);
    logic [15:0] tiles;
    logic [15:0] prod;
    tiles = {10'd0, dim[7:2]} + {15'd0, |dim[1:0]};
    prod  = {8'd0, outer} * tiles;
    return IDX_W'(prod);
  endfunction

  logic [3:0]       state;
  logic [7:0]       k_q, m_q, n_q;
  logic [IDX_W-1:0] na, nb, nc;
  logic [IDX_W-1:0] a_idx, b_idx, rd_cnt;
  logic             cfg_zero;

  assign cfg_zero     = (cfg_k == 8'd0) || (cfg_m == 8'd0) || (cfg_n == 8'd0);

  assign cfg_ready    = (state == IDLE);
  assign wr_ready     = (state == LOAD_A) || (state == LOAD_B);
  assign A_wr_en      = (state == LOAD_A) && wr_valid;
  assign B_wr_en      = (state == LOAD_B) && wr_valid;
  assign A_index      = a_idx;
  assign B_index      = b_idx;
  assign A_data_in    = wr_data;
  assign B_data_in    = wr_data;
  assign C_index      = rd_cnt;
  assign tpu_in_valid = (state == START);
  assign tpu_K        = k_q;
  assign tpu_M        = m_q;
  assign tpu_N        = n_q;
  assign buf_own      = !((state == START) || (state == WAIT_HI) || (state == WAIT_LO));
  assign done         = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k_q       <= '0;
      m_q       <= '0;
      n_q       <= '0;
      na        <= '0;
      nb        <= '0;
      nc        <= '0;
      a_idx     <= '0;
      b_idx     <= '0;
      rd_cnt    <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_zero) begin
              cfg_err <= 1'b1;
            end else begin
              k_q    <= cfg_k;
              m_q    <= cfg_m;
              n_q    <= cfg_n;
              na     <= tile_words(cfg_k, cfg_m);
              nb     <= tile_words(cfg_k, cfg_n);
              nc     <= tile_words(cfg_m, cfg_n);
              a_idx  <= '0;
              b_idx  <= '0;
              rd_cnt <= '0;
              state  <= LOAD_A;
            end
          end
        end
        LOAD_A: begin
          if (wr_valid) begin
            a_idx <= a_idx + ONE;
            if (a_idx == na - ONE) state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (wr_valid) begin
            b_idx <= b_idx + ONE;
            if (b_idx == nb - ONE) state <= START;
          end
        end
        START:   state <= WAIT_HI;
        WAIT_HI: if (tpu_busy)  state <= WAIT_LO;
        WAIT_LO: if (!tpu_busy) state <= RD_ISSUE;
        // C read: index presented in ISSUE, buffer output captured in CAP
        RD_ISSUE: state <= RD_CAP;
        RD_CAP: begin
          res_data  <= C_data_out;
          res_valid <= 1'b1;
          res_last  <= (rd_cnt == nc - ONE);
          state     <= RD_HOLD;
        end
        RD_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            rd_cnt    <= rd_cnt + ONE;
            state     <= res_last ? DONE : RD_ISSUE;
          end
        end
        DONE: begin
          a_idx  <= '0;
          b_idx  <= '0;
          rd_cnt <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_host_bridge.sv
// Scoreboard bench for tpu_host_bridge: buffer/TPU models around the bridge,
// expected writes and C words queued at stimulus time and checked by a monitor.
module tb_tpu_host_bridge;
  localparam int IDX_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid, cfg_ready, cfg_err;
  logic [7:0]       cfg_k, cfg_m, cfg_n;
  logic             wr_valid, wr_ready;
  logic [31:0]      wr_data;
  logic             res_valid, res_ready, res_last, done, buf_own;
  logic [127:0]     res_data;
  logic             A_wr_en, B_wr_en;
  logic [IDX_W-1:0] A_index, B_index, C_index;
  logic [31:0]      A_data_in, B_data_in;
  logic [127:0]     C_data_out;
  logic             tpu_in_valid, tpu_busy;
  logic [7:0]       tpu_K, tpu_M, tpu_N;

  tpu_host_bridge #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_k(cfg_k), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_err(cfg_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .done(done), .buf_own(buf_own),
    .A_wr_en(A_wr_en), .A_index(A_index), .A_data_in(A_data_in),
    .B_wr_en(B_wr_en), .B_index(B_index), .B_data_in(B_data_in),
    .C_index(C_index), .C_data_out(C_data_out),
    .tpu_in_valid(tpu_in_valid), .tpu_K(tpu_K), .tpu_M(tpu_M), .tpu_N(tpu_N),
    .tpu_busy(tpu_busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [128:0] qa[$], qb[$], qc[$];
  logic [31:0]  wa[$], wb[$];
  logic [127:0] cbuf [0:65535];

  logic [7:0] job_k, job_m, job_n, job_tag;
  int job_nc, job_delay, job_len;
  int stall_word = -1, stall_left = 0, stall_cycles = 0;
  int hs_cnt = 0, tpu_pulses = 0, done_cnt = 0;

  function automatic void check(string name, logic [128:0] act, logic [128:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void flag(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event occurred, expected none", name);
  endfunction

  function automatic logic [127:0] cword(input logic [7:0] tag, input int i);
    return {24'hC0FFEE, tag, 16'h0000, 16'(i), ~32'(i), 32'h5A5A0000 ^ 32'(i)};
  endfunction

  // Synchronous C buffer, one-cycle read latency
  always @(posedge clk) C_data_out <= cbuf[C_index];

  // Monitor / scoreboard
  initial begin
    logic [128:0] e;
    logic [127:0] held_data;
    logic [IDX_W-1:0] held_idx;
    bit held_ok;
    held_ok = 0;
    held_data = '0;
    held_idx = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_ok = 0;
      end else begin
        if (A_wr_en) begin
          if (qa.size() == 0) flag("a_write_unexpected");
          else begin e = qa.pop_front(); check("a_write", 129'({A_index, A_data_in}), e); end
        end
        if (B_wr_en) begin
          if (qb.size() == 0) flag("b_write_unexpected");
          else begin e = qb.pop_front(); check("b_write", 129'({B_index, B_data_in}), e); end
        end
        if (res_valid && res_ready) begin
          if (qc.size() == 0) flag("c_word_unexpected");
          else begin e = qc.pop_front(); check("c_word", {res_last, res_data}, e); end
          hs_cnt++;
        end
        if (res_valid && !res_ready) begin
          stall_cycles++;
          if (held_ok) begin
            check("stall_res_data", 129'(res_data), 129'(held_data));
            check("stall_c_index", 129'(C_index), 129'(held_idx));
          end
          held_ok = 1;
          held_data = res_data;
          held_idx = C_index;
        end else begin
          held_ok = 0;
        end
        if (tpu_in_valid) tpu_pulses++;
        if (tpu_busy) check("buf_own_busy", 129'(buf_own), 129'(0));
        if (done) done_cnt++;
      end
    end
  end

  // Host result-ready driver: stalls one chosen word for 10 cycles
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_word >= 0 && hs_cnt == stall_word && res_valid && stall_left > 0) begin
        res_ready = 1'b0;
        stall_left--;
      end else begin
        res_ready = 1'b1;
      end
    end
  end

  // TPU model: busy rises job_delay cycles after start, stays high job_len cycles
  initial begin
    tpu_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tpu_in_valid) begin
        check("tpu_kmn", 129'({tpu_K, tpu_M, tpu_N}), 129'({job_k, job_m, job_n}));
        if (job_delay == 0) tpu_busy = 1'b1;
        else begin
          repeat (job_delay) @(posedge clk);
          #1;
          tpu_busy = 1'b1;
        end
        for (int i = 0; i < job_nc; i++) cbuf[i] = cword(job_tag, i);
        repeat (job_len) @(posedge clk);
        #1;
        tpu_busy = 1'b0;
        @(negedge clk);
        check("buf_own_wait_lo", 129'(buf_own), 129'(0));
        @(negedge clk);
        check("buf_own_issue", 129'(buf_own), 129'(1));
        check("first_c_index", 129'(C_index), 129'(0));
        check("res_valid_issue", 129'(res_valid), 129'(0));
        @(negedge clk);
        check("res_valid_cap", 129'(res_valid), 129'(0));
        @(negedge clk);
        check("res_valid_first", 129'(res_valid), 129'(1));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n);
    cfg_valid = 1'b1; cfg_k = k; cfg_m = m; cfg_n = n;
    @(negedge clk);
    check("cfg_ready", 129'(cfg_ready), 129'(1));
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    bit ok;
    ok = 0;
    wr_valid = 1'b1;
    wr_data = w;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = wr_ready;
    end
    if (!ok) flag("wr_ready_timeout");
    step();
    wr_valid = 1'b0;
  endtask

  task automatic idle_words(input int n);
    wr_valid = 1'b0;
    repeat (n) begin
      wr_data = $urandom;
      step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg_ready"}, 129'(cfg_ready), 129'(1));
    check({tag, "_buf_own"}, 129'(buf_own), 129'(1));
    check({tag, "_ctrl_zero"},
          129'({wr_ready, res_valid, res_last, done, cfg_err, tpu_in_valid, A_wr_en, B_wr_en}),
          129'(0));
    check({tag, "_indices"}, 129'({A_index, B_index, C_index}), 129'(0));
    check({tag, "_res_data"}, 129'(res_data), 129'(0));
  endtask

  task automatic flush_queues(input string tag);
    check({tag, "_pending_a"}, 129'(qa.size()), 129'(0));
    check({tag, "_pending_b"}, 129'(qb.size()), 129'(0));
    check({tag, "_pending_c"}, 129'(qc.size()), 129'(0));
    qa.delete(); qb.delete(); qc.delete();
  endtask

  task automatic run_job(input string tag, input logic [7:0] k, input logic [7:0] m,
                         input logic [7:0] n, input int na, input int nb, input int nc,
                         input logic [7:0] ctag, input int delay, input int len,
                         input bit gaps, input int stall);
    bit got;
    job_k = k; job_m = m; job_n = n; job_nc = nc; job_tag = ctag;
    job_delay = delay; job_len = len;
    stall_word = stall; stall_left = 10; stall_cycles = 0;
    hs_cnt = 0; tpu_pulses = 0; done_cnt = 0;
    for (int i = 0; i < na; i++) qa.push_back(129'({16'(i), wa[i]}));
    for (int i = 0; i < nb; i++) qb.push_back(129'({16'(i), wb[i]}));
    for (int i = 0; i < nc; i++) qc.push_back({i == nc - 1, cword(ctag, i)});
    send_cfg(k, m, n);
    for (int i = 0; i < na; i++) begin
      if (gaps && (i % 2 == 1)) idle_words($urandom_range(1, 3));
      send_word(wa[i]);
    end
    for (int i = 0; i < nb; i++) begin
      if (gaps && (i % 2 == 1)) idle_words($urandom_range(1, 3));
      send_word(wb[i]);
    end
    @(negedge clk);
    check({tag, "_tpu_in_valid_after_b"}, 129'(tpu_in_valid), 129'(1));
    got = 0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      got = done;
    end
    if (!got) flag({tag, "_done_timeout"});
    check({tag, "_done_state"}, 129'({res_valid, cfg_ready}), 129'(0));
    @(negedge clk);
    check({tag, "_after_done"}, 129'({done, cfg_ready}), 129'(1));
    check({tag, "_done_pulses"}, 129'(done_cnt), 129'(1));
    check({tag, "_tpu_pulses"}, 129'(tpu_pulses), 129'(1));
    check({tag, "_c_handshakes"}, 129'(hs_cnt), 129'(nc));
    if (stall >= 0) check({tag, "_stall_cycles"}, 129'(stall_cycles), 129'(10));
    flush_queues(tag);
    stall_word = -1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_valid = 1'b0; cfg_k = '0; cfg_m = '0; cfg_n = '0;
    wr_valid = 1'b0; wr_data = '0;
    for (int i = 0; i < 64; i++) cbuf[i] = '0;
    rst_n = 1'b0;
    step();
    check_reset_outputs("por");
    step();
    rst_n = 1'b1;
    step();

    // K=2 M=4 N=4: na=2 nb=2 nc=4
    wa = '{32'h01020304, 32'h05060708};
    wb = '{32'h01000000, 32'h00010000};
    run_job("job1", 8'd2, 8'd4, 8'd4, 2, 2, 4, 8'h01, 0, 4, 1'b0, -1);

    // K=3 M=5 N=9: na=6 nb=9 nc=15, busy rises 3 cycles after start for 20 cycles
    wa.delete(); wb.delete();
    for (int i = 0; i < 6; i++) wa.push_back(32'hA3000000 + 32'(i));
    for (int i = 0; i < 9; i++) wb.push_back(32'hB3000000 + 32'(i));
    run_job("job2", 8'd3, 8'd5, 8'd9, 6, 9, 15, 8'h02, 3, 20, 1'b0, -1);

    // Zero M: error pulse, no loading, host words ignored
    tpu_pulses = 0;
    wr_valid = 1'b1; wr_data = 32'hDEADBEEF;
    cfg_valid = 1'b1; cfg_k = 8'd2; cfg_m = 8'd0; cfg_n = 8'd4;
    @(negedge clk);
    check("err_cfg_ready", 129'(cfg_ready), 129'(1));
    check("err_wr_ready", 129'(wr_ready), 129'(0));
    step();
    cfg_valid = 1'b0;
    @(negedge clk);
    check("err_pulse", 129'(cfg_err), 129'(1));
    check("err_cfg_ready_after", 129'(cfg_ready), 129'(1));
    step();
    @(negedge clk);
    check("err_pulse_end", 129'(cfg_err), 129'(0));
    repeat (3) step();
    wr_valid = 1'b0;
    check("err_no_tpu_start", 129'(tpu_pulses), 129'(0));
    check("err_cfg_ready_idle", 129'(cfg_ready), 129'(1));

    // K=2 M=4 N=8: na=2 nb=4 nc=8, write gaps and a 10-cycle stall on word 2
    wa.delete(); wb.delete();
    for (int i = 0; i < 2; i++) wa.push_back(32'hA4000000 + 32'(i));
    for (int i = 0; i < 4; i++) wb.push_back(32'hB4000000 + 32'(i));
    run_job("job3", 8'd2, 8'd4, 8'd8, 2, 4, 8, 8'h03, 1, 3, 1'b1, 2);

    // Reset during LOAD_B after one of two B words
    qa.push_back(129'({16'd0, 32'h11111111}));
    qa.push_back(129'({16'd1, 32'h22222222}));
    qb.push_back(129'({16'd0, 32'h33333333}));
    tpu_pulses = 0;
    send_cfg(8'd2, 8'd4, 8'd4);
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step();
    rst_n = 1'b1;
    step();
    check("midrst_no_tpu_start", 129'(tpu_pulses), 129'(0));
    flush_queues("midrst");

    // K=1 M=1 N=1: single word, res_last on the first
    wa = '{32'hA5000001};
    wb = '{32'hB5000001};
    run_job("job4", 8'd1, 8'd1, 8'd1, 1, 1, 1, 8'h04, 0, 2, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
